// File: rtl/demux32bit1to5_reg.sv
`default_nettype none
// ============================================================================
//  Module   : demux32bit1to5_reg
//  Purpose  : Registered 1-to-5 demultiplexer. One WIDTH-bit word per cycle
//             is routed by in_sel into one of five holding slots. Each slot
//             keeps its word and raises out_valid[k] until the consumer
//             acknowledges it with out_ack[k]. Selects 5..7 are illegal: the
//             word is accepted, dropped and flagged with a one-cycle sel_err.
//  Ports    : Clk       - rising-edge clock
//             Reset     - synchronous, active-high reset
//             in_data   - word to route
//             in_sel    - destination slot (0..4 legal)
//             in_valid  - in_data / in_sel valid this cycle
//             in_ready  - word accepted this cycle (combinational)
//             out_data  - slot k at [k*WIDTH +: WIDTH], registered
//             out_valid - slot k holds an unacknowledged word
//             out_ack   - consumer of slot k takes the word this cycle
//             sel_err   - one-cycle pulse after an illegal-select transfer
//             err_cnt   - saturating illegal-transfer count
//                         (present only with DEMUX_ERR_CNT_EN defined)
//  Config   : `define DEMUX_ERR_CNT_EN to add err_cnt and its counter.
//  Revision : 1.0 - initial release
// ============================================================================
module demux32bit1to5_reg #(
    parameter int WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [2:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [5*WIDTH-1:0] out_data,
    output logic [4:0]         out_valid,
    input  logic [4:0]         out_ack,
`ifdef DEMUX_ERR_CNT_EN
    output logic               sel_err,
    output logic [7:0]         err_cnt
`else
    output logic               sel_err
`endif
);

    localparam int          c_num_slots = 5;
    localparam logic [2:0]  c_max_sel   = 3'd4;

    // Per-slot state encoding: the FULL state is exactly out_valid[k].
    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    logic                   w_sel_legal;
    logic                   w_in_ready;
    logic                   w_xfer;
    logic                   w_illegal_xfer;
    logic [c_num_slots-1:0] w_slot_ready;
    logic [c_num_slots-1:0] w_load;
    logic                   r_sel_err;

    assign w_sel_legal = (in_sel <= c_max_sel);

    // A slot can take a word when it is empty, or when it is full and its
    // consumer is draining it in this same cycle (no bubble on reload).
    // Illegal selects are always accepted so the producer never stalls on
    // a bad address. in_valid deliberately plays no part here.
    always_comb begin
        w_in_ready = 1'b1;
        case (in_sel)
            3'd0:    w_in_ready = w_slot_ready[0];
            3'd1:    w_in_ready = w_slot_ready[1];
            3'd2:    w_in_ready = w_slot_ready[2];
            3'd3:    w_in_ready = w_slot_ready[3];
            3'd4:    w_in_ready = w_slot_ready[4];
            default: w_in_ready = 1'b1;
        endcase
    end

    assign in_ready       = w_in_ready;
    assign w_xfer         = in_valid & w_in_ready;
    assign w_illegal_xfer = w_xfer & ~w_sel_legal;

    // ------------------------------------------------------------------
    // Five independent slots: each is a two-state FSM plus a data register.
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < c_num_slots; k++) begin : g_slot
            slot_state_t      r_state;
            slot_state_t      w_next;
            logic [WIDTH-1:0] r_data;

            assign w_slot_ready[k] = (r_state == S_EMPTY) | out_ack[k];
            assign w_load[k]       = w_xfer & w_sel_legal & (in_sel == 3'(k));

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    r_state <= S_EMPTY;
                end else begin
                    r_state <= w_next;
                end
            end

            // A load wins over an ack on the same slot: the slot stays FULL
            // and takes the new word.
            always_comb begin
                w_next = r_state;
                case (r_state)
                    S_EMPTY: begin
                        if (w_load[k]) begin
                            w_next = S_FULL;
                        end
                    end
                    S_FULL: begin
                        if (w_load[k]) begin
                            w_next = S_FULL;
                        end else if (out_ack[k]) begin
                            w_next = S_EMPTY;
                        end
                    end
                    default: w_next = S_EMPTY;
                endcase
            end

            // The word stays on out_data after an ack; only a load changes it.
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    r_data <= '0;
                end else if (w_load[k]) begin
                    r_data <= in_data;
                end
            end

            assign out_valid[k]                  = (r_state == S_FULL);
            assign out_data[k*WIDTH +: WIDTH]    = r_data;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Illegal-select reporting. The flag is re-evaluated every cycle, so
    // consecutive illegal transfers keep it high continuously.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= w_illegal_xfer;
        end
    end

    assign sel_err = r_sel_err;

`ifdef DEMUX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Saturates at all-ones so a flood of bad selects never wraps to a
    // misleadingly small value.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_err_cnt <= 8'h00;
        end else if (w_illegal_xfer && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire
